// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, the stage-index type and the redirect clamp helper for
// the pipeline controller.
package common;

  localparam int NSTAGE_DEFAULT     = 5;
  localparam int HOLD_STAGE_DEFAULT = 1;
  localparam int STAGE_W            = $clog2(NSTAGE_DEFAULT);

  // Index of a pipeline stage for the default pipeline depth.
  typedef logic [STAGE_W-1:0] stage_idx_t;

  // Out-of-range redirect indices are treated as the oldest stage.
  function automatic int clamp_stage(input int idx, input int nstage);
    return (idx >= nstage) ? nstage - 1 : idx;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stage status and hazard requests in, per-stage
// valid/flush state and the global advance/retire strobes out.
interface pipe_ctrl_if
  import common::*;
#(
  parameter int NSTAGE = NSTAGE_DEFAULT
);

  localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  logic [NSTAGE-1:0] stage_ready;
  logic              fetch_valid;
  logic              hold;
  logic              redirect_valid;
  logic [SW-1:0]     redirect_stage;
  logic              advance;
  logic [NSTAGE-1:0] valid;
  logic [NSTAGE-1:0] flush;
  logic              retire;

  // The pipeline datapath drives requests and observes control state.
  modport master (
    output stage_ready, fetch_valid, hold, redirect_valid, redirect_stage,
    input  advance, valid, flush, retire
  );

  // The controller consumes requests and produces control state.
  modport slave (
    input  stage_ready, fetch_valid, hold, redirect_valid, redirect_stage,
    output advance, valid, flush, retire
  );

endinterface

// File: rtl/sat_counter.sv
// CW-bit event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count
);

  // Count enabled events, holding at all-ones once reached.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!rst) begin
      count <= '0;
    end else if (en && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: tracks per-stage valid bits, applies
// load-use holds and redirects, and keeps stall/bubble/flush statistics.
module pipe_ctrl
  import common::*;
#(
  parameter int NSTAGE     = NSTAGE_DEFAULT,
  parameter int HOLD_STAGE = HOLD_STAGE_DEFAULT,
  parameter int CW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] bubble_cnt,
  output logic [CW-1:0] flush_cnt
);

  if (NSTAGE < 2 || NSTAGE > 8) begin : g_bad_nstage
    $error("pipe_ctrl: NSTAGE must be in 2..8");
  end
  if (HOLD_STAGE < 0 || HOLD_STAGE > NSTAGE - 2) begin : g_bad_hold
    $error("pipe_ctrl: HOLD_STAGE must be in 0..NSTAGE-2");
  end

  logic [NSTAGE-1:0] valid_q;
  logic [NSTAGE-1:0] valid_d;
  logic [NSTAGE-1:0] shifted;
  int                kill_top;
  logic              do_redirect;
  logic              do_hold;

  // The pipe moves only when every stage agrees; hazards never gate this.
  assign bus.advance = &bus.stage_ready;
  assign bus.valid   = valid_q;
  assign bus.retire  = bus.advance & valid_q[NSTAGE-1];

  // Hazard requests only take effect on a cycle the pipe actually moves.
  assign do_redirect = bus.advance & bus.redirect_valid;
  assign do_hold     = bus.advance & bus.hold & ~bus.redirect_valid;

  // Highest stage killed by a redirect, clamped to the oldest stage.
  always_comb begin
    kill_top = clamp_stage(int'(bus.redirect_stage), NSTAGE);
  end

  // Kill strobes go to the stages younger than the redirecting stage.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    bus.flush = '0;
    if (do_redirect) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (i < kill_top) bus.flush[i] = 1'b1;
      end
    end
  end

  // Next valid vector, priority redirect > hold > plain shift.
  always_comb begin
    shifted = {valid_q[NSTAGE-2:0], bus.fetch_valid};
    valid_d = valid_q;
    if (bus.advance) begin
      if (bus.redirect_valid) begin
        for (int i = 0; i < NSTAGE; i++) begin
          valid_d[i] = (i <= kill_top) ? 1'b0 : shifted[i];
        end
      end else if (bus.hold) begin
        for (int i = 0; i < NSTAGE; i++) begin
          if (i <= HOLD_STAGE)          valid_d[i] = valid_q[i];
          else if (i == HOLD_STAGE + 1) valid_d[i] = 1'b0;
          else                          valid_d[i] = shifted[i];
        end
      end else begin
        valid_d = shifted;
      end
    end
  end

  // Valid bits register; reset empties the pipe immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (~bus.advance),
    .count (stall_cnt)
  );

  sat_counter #(.CW(CW)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (do_hold),
    .count (bubble_cnt)
  );

  sat_counter #(.CW(CW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (do_redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: 5 stages, hold stage 1, 4-bit counters.
module tb_pipe_ctrl;
  import common::*;

  localparam int NS = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_if #(.NSTAGE(NS)) bus ();

  pipe_ctrl #(.NSTAGE(NS), .HOLD_STAGE(1), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_cnts(input string tag, input int s, input int b, input int f);
    check({tag, "_stall"},  32'(stall_cnt),  32'(s));
    check({tag, "_bubble"}, 32'(bubble_cnt), 32'(b));
    check({tag, "_flush"},  32'(flush_cnt),  32'(f));
  endtask

  initial begin
    stage_idx_t rs;
    rst                = 1'b0;
    bus.stage_ready    = '1;
    bus.fetch_valid    = 1'b0;
    bus.hold           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_stage = '0;
    #1;
    check("rst_valid",  32'(bus.valid),  32'h0);
    check("rst_flush",  32'(bus.flush),  32'h0);
    check("rst_retire", 32'(bus.retire), 32'h0);
    check_cnts("rst", 0, 0, 0);

    // Fill an empty pipe.
    step(2);
    rst             = 1'b1;
    bus.fetch_valid = 1'b1;
    check("fill_adv", 32'(bus.advance), 32'h1);
    step(1); check("fill1", 32'(bus.valid), 32'h01);
    step(1); check("fill2", 32'(bus.valid), 32'h03);
    step(1); check("fill3", 32'(bus.valid), 32'h07);
    step(1); check("fill4", 32'(bus.valid), 32'h0f);
    check("fill4_retire", 32'(bus.retire), 32'h0);
    step(1); check("fill5", 32'(bus.valid), 32'h1f);
    check("fill5_retire", 32'(bus.retire), 32'h1);
    check_cnts("fill", 0, 0, 0);

    // Stage 3 not ready: pipe frozen, hold ignored.
    bus.stage_ready = 5'b10111;
    bus.hold        = 1'b1;
    #1;
    check("stall_adv",    32'(bus.advance), 32'h0);
    check("stall_retire", 32'(bus.retire),  32'h0);
    step(3);
    check("stall_valid", 32'(bus.valid), 32'h1f);
    check_cnts("stall", 3, 0, 0);

    // Load-use hold for one advance: bubble into stage 2.
    bus.stage_ready = '1;
    #1;
    check("hold_flush", 32'(bus.flush), 32'h0);
    step(1);
    check("hold_valid", 32'(bus.valid), 32'h1b);
    check_cnts("hold", 3, 1, 0);
    bus.hold = 1'b0;
    step(1); check("hold_shift1", 32'(bus.valid), 32'h17);
    step(1); check("hold_shift2", 32'(bus.valid), 32'h0f);
    step(1); check("hold_shift3", 32'(bus.valid), 32'h1f);

    // Redirect from stage 3 on a full pipe.
    rs                 = 3'd3;
    bus.redirect_valid = 1'b1;
    bus.redirect_stage = rs;
    #1;
    check("redir_flush", 32'(bus.flush),   32'h07);
    check("redir_adv",   32'(bus.advance), 32'h1);
    step(1);
    bus.redirect_valid = 1'b0;
    #1;
    check("redir_valid", 32'(bus.valid), 32'h10);
    check("redir_flush_after", 32'(bus.flush), 32'h0);
    check("redir_retire", 32'(bus.retire), 32'h1);
    check_cnts("redir", 3, 1, 1);
    step(1);
    check("redir_next", 32'(bus.valid), 32'h01);

    // Hold and redirect together: redirect wins, no bubble.
    step(4);
    check("both_pre", 32'(bus.valid), 32'h1f);
    rs                 = 3'd2;
    bus.hold           = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_stage = rs;
    #1;
    check("both_flush", 32'(bus.flush), 32'h03);
    step(1);
    check("both_valid", 32'(bus.valid), 32'h18);
    check_cnts("both", 3, 1, 2);

    // Out-of-range redirect index treated as the oldest stage.
    rs                 = 3'd7;
    bus.hold           = 1'b0;
    bus.redirect_stage = rs;
    #1;
    check("clamp_flush", 32'(bus.flush), 32'h0f);
    step(1);
    check("clamp_valid", 32'(bus.valid), 32'h00);
    check_cnts("clamp", 3, 1, 3);
    bus.redirect_valid = 1'b0;

    // Long stall saturates the 4-bit counter.
    bus.stage_ready = '0;
    step(11); check("sat_14", 32'(stall_cnt), 32'd14);
    step(1);  check("sat_15", 32'(stall_cnt), 32'd15);
    step(8);  check("sat_hold", 32'(stall_cnt), 32'd15);
    check("sat_valid", 32'(bus.valid), 32'h00);

    // Asynchronous reset mid-run, with requests pending.
    bus.stage_ready = '1;
    step(2);
    check("pre_rst_valid", 32'(bus.valid), 32'h03);
    @(posedge clk);
    #2;
    rst                = 1'b0;
    bus.hold           = 1'b1;
    bus.redirect_valid = 1'b1;
    #1;
    check("arst_valid",  32'(bus.valid),  32'h0);
    check("arst_retire", 32'(bus.retire), 32'h0);
    check_cnts("arst", 0, 0, 0);
    step(2);
    check("arst_hold_valid", 32'(bus.valid), 32'h0);
    bus.hold           = 1'b0;
    bus.redirect_valid = 1'b0;
    rst                = 1'b1;
    step(1);
    check("post_rst_valid", 32'(bus.valid), 32'h01);
    check_cnts("post_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
